// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state encoding and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Request/status/read-port bundle between the cipher datapath and the key-schedule controller.
interface key_sched_ctrl_if #(
  parameter int IDX_W = 4
);
  import aes_pkg::*;

  logic                 start;
  logic [AES_KEY_W-1:0] key_in;
  logic                 busy;
  logic                 done;
  logic                 keys_valid;
  logic [IDX_W-1:0]     rd_idx;
  logic [AES_KEY_W-1:0] rd_data;

  modport master (
    output start, key_in, rd_idx,
    input  busy, done, keys_valid, rd_data
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, done, keys_valid, rd_data
  );

endinterface

// File: rtl/key_expand_round_rc.sv
// Combinational AES-128 key-expansion round; rcon is supplied by the caller instead of derived from a round index.
module key_expand_round_rc
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key_prev,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] key_next
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse as x^254 by square-and-multiply (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_prev[127:96];
  assign w1 = key_prev[95:64];
  assign w2 = key_prev[63:32];
  assign w3 = key_prev[31:0];

  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign temp = sub ^ {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next = {n0, n1, n2, n3};

endmodule

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key schedule: one shared round unit, keys 0..10 held in a local store, registered read port.
//
// state  | meaning
// IDLE   | no schedule since reset or abort; store contents hidden
// EXPAND | one round key written per cycle into slots 1..10
// DONE   | full schedule held; keys_valid high
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int IDX_W      = 4
)(
  input  logic           clk,
  input  logic           rst,
  key_sched_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  ks_state_e            state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           rcon_q, rcon_d;
  logic                 done_q, done_d;
  logic                 kv_q, kv_d;
  logic                 load, step;
  logic [AES_KEY_W-1:0] work_q;
  logic [AES_KEY_W-1:0] round_key;
  logic [AES_KEY_W-1:0] rd_data_q;
  logic [AES_KEY_W-1:0] store [0:NUM_ROUNDS];

  key_expand_round_rc u_round (
    .key_prev (work_q),
    .rcon     (rcon_q),
    .key_next (round_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcon_q    <= RCON_INIT;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      // A restart hides the old schedule from its very first edge.
      if (kv_q && !load && (bus.rd_idx <= LAST_IDX))
        rd_data_q <= store[bus.rd_idx];
      else
        rd_data_q <= '0;
    end
  end

  // Store and working register need no reset; reads are gated by keys_valid.
  always_ff @(posedge clk) begin
    if (load) begin
      store[0] <= bus.key_in;
      work_q   <= bus.key_in;
    end else if (step) begin
      store[cnt_q] <= round_key;
      work_q       <= round_key;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = EXPAND;
          cnt_d   = IDX_W'(1);
          rcon_d  = RCON_INIT;
          kv_d    = 1'b0;
        end
      end
      EXPAND: begin
        step   = 1'b1;
        rcon_d = xtime(rcon_q);
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        kv_d    = 1'b0;
      end
    endcase
  end

  assign bus.busy       = (state_q == EXPAND);
  assign bus.done       = done_q;
  assign bus.keys_valid = kv_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: directed scenarios plus random keys against a word-level FIPS-197 model.
module tb_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_sched_ctrl_if bus ();

  key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] want_keys [11];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    logic [14:0] poly;
    prod = '0;
    poly = 15'h011b;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (poly << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [8:0]  rc;
    rc   = 9'h001;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc[7:0], 24'h0};
        rc = rc << 1;
        if (rc[8]) rc = rc ^ 9'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) want_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic rd_const(input string tag, input int idx, input logic [127:0] want);
    bus.rd_idx = 4'(idx);
    tick();
    chk(tag, bus.rd_data, want);
  endtask

  task automatic verify_store();
    for (int idx = 0; idx < 16; idx++) begin
      bus.rd_idx = 4'(idx);
      tick();
      chk($sformatf("rd_key[%0d]", idx), bus.rd_data, (idx <= 10) ? want_keys[idx] : 128'h0);
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int idx = 0; idx < 16; idx++) begin
      bus.rd_idx = 4'(idx);
      tick();
      chk($sformatf("%s[%0d]", tag, idx), bus.rd_data, 128'h0);
    end
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_valid"}, bus.keys_valid, 0);
  endtask

  // Start an expansion; start stays high for 'hold' cycles with key_in swapped to 'alt' after the first.
  task automatic expand(input logic [127:0] key, input int hold, input logic [127:0] alt);
    int nb;
    int d0;
    d0          = done_cnt;
    bus.key_in  = key;
    bus.start   = 1'b1;
    bus.rd_idx  = 4'($urandom_range(0, 15));
    tick();
    chk("start_busy", bus.busy, 1);
    chk("start_valid", bus.keys_valid, 0);
    chk("start_rd_zero", bus.rd_data, 128'h0);
    nb = 0;
    while (bus.busy === 1'b1 && nb < 30) begin
      nb++;
      if (nb < hold) begin
        bus.start  = 1'b1;
        bus.key_in = alt;
      end else begin
        bus.start = 1'b0;
      end
      bus.rd_idx = 4'($urandom_range(0, 15));
      tick();
      chk("window_rd_zero", bus.rd_data, 128'h0);
      if (bus.busy === 1'b1) chk("window_valid", bus.keys_valid, 0);
    end
    bus.start = 1'b0;
    chk("busy_cycles", 128'(nb), 128'd10);
    chk("done_pulse", bus.done, 1);
    chk("valid_at_done", bus.keys_valid, 1);
    tick();
    chk("done_drop", bus.done, 0);
    chk("valid_hold", bus.keys_valid, 1);
    chk("done_count", 128'(done_cnt - d0), 128'd1);
  endtask

  initial begin
    logic [127:0] rkey, akey;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.rd_idx = '0;
    build_sbox();
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.keys_valid, 0);
    chk("rst_rd", bus.rd_data, 128'h0);
    rst = 1'b0;

    // Reads before any start
    sweep_zero("pre_start");

    // FIPS-197 key
    expand(FIPS_KEY, 1, ZERO_KEY);
    rd_const("fips_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_const("fips_rk2", 2, 128'hf2c295f27a96b9435935807a7359f67f);
    rd_const("fips_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_const("fips_rk0", 0, FIPS_KEY);
    model(FIPS_KEY);
    verify_store();

    // Key change from DONE to all-zero key
    expand(ZERO_KEY, 1, ZERO_KEY);
    rd_const("zero_rk1", 1, 128'h62636363626363636263636362636363);
    rd_const("zero_rk10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    rd_const("zero_rk11", 11, 128'h0);
    rd_const("zero_rk15", 15, 128'h0);
    model(ZERO_KEY);
    verify_store();

    // start held 5 cycles, key_in changed mid-expansion
    expand(FIPS_KEY, 5, ZERO_KEY);
    rd_const("hold_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model(FIPS_KEY);
    verify_store();

    // Reset at the 5th EXPAND cycle
    bus.key_in = FIPS_KEY;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("abort_pre_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.keys_valid, 0);
    sweep_zero("abort_rd");
    expand(FIPS_KEY, 1, ZERO_KEY);
    rd_const("reexp_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_const("reexp_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model(FIPS_KEY);
    verify_store();

    // Random keys, sometimes with start held and key_in disturbed
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      akey = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey, int'($urandom_range(1, 4)), akey);
      model(rkey);
      verify_store();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
